// File: rtl/stopwatch_pkg.sv
// Shared state encoding and BCD digit limits for the lap stopwatch.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_RUN,
      S_LAP,
      S_PAUSE
   } state_e;

   localparam int BCD_MAX_DEC = 9;
   localparam int BCD_MAX_SEX = 5;

   // Odd-index digits are tens of seconds/minutes when counting sexagesimally.
   function automatic int digit_max(input int idx, input int sexagesimal);
      return (sexagesimal != 0 && (idx % 2) == 1) ? BCD_MAX_SEX : BCD_MAX_DEC;
   endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit that counts 0..MAX; carry flags the increment that rolls it over.
module bcd_digit_cnt #(
   parameter int MAX = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] digit,
   output logic       carry
);

   logic [3:0] digit_q;

   assign carry = inc && (digit_q == 4'(MAX));
   assign digit = digit_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_q <= '0;
      end else if (clr) begin
         digit_q <= '0;
      end else if (inc) begin
         digit_q <= carry ? 4'd0 : digit_q + 4'd1;
      end
   end

endmodule

// File: rtl/stopwatch_lap_bcd.sv
// BCD stopwatch with start/stop, lap freeze and clear, driven by two edge-detected buttons.
module stopwatch_lap_bcd
   import stopwatch_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int SEXAGESIMAL = 1,
   parameter int TICK_DIV    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  push_m,
   input  logic                  push_lap,
   output logic [4*N_DIGITS-1:0] clk_count,
   output logic                  running,
   output logic                  lap_active,
   output logic                  wrap
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_e                state_q, state_d;
   logic                  m_prev_q, lap_prev_q;
   logic [PRESC_W-1:0]    presc_q;
   logic [4*N_DIGITS-1:0] live_count;
   logic [4*N_DIGITS-1:0] lap_q;
   logic [N_DIGITS:0]     inc_chain;
   logic                  running_q, lap_active_q, wrap_q;
   logic                  m_ev, lap_ev, in_run, tick;
   logic                  lap_capture, lap_clear, cnt_clr;

   // A coincident start/stop press wins; the lap press is dropped.
   assign m_ev   = push_m & ~m_prev_q;
   assign lap_ev = push_lap & ~lap_prev_q & ~m_ev;

   assign in_run  = (state_q == S_RUN) || (state_q == S_LAP);
   assign tick    = in_run && (presc_q == PRESC_W'(TICK_DIV - 1));
   assign cnt_clr = ~enable | lap_clear;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      lap_capture = 1'b0;
      lap_clear   = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_ARMED;
            S_ARMED: if (m_ev) state_d = S_RUN;
            S_RUN: begin
               if (m_ev) begin
                  state_d = S_PAUSE;
               end else if (lap_ev) begin
                  state_d     = S_LAP;
                  lap_capture = 1'b1;
               end
            end
            S_LAP: begin
               if (m_ev)        state_d = S_PAUSE;
               else if (lap_ev) state_d = S_RUN;
            end
            S_PAUSE: begin
               if (m_ev) begin
                  state_d = S_RUN;
               end else if (lap_ev) begin
                  state_d   = S_ARMED;
                  lap_clear = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
         wrap_q       <= 1'b0;
         m_prev_q     <= 1'b0;
         lap_prev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         running_q    <= (state_d == S_RUN) || (state_d == S_LAP);
         lap_active_q <= (state_d == S_LAP);
         wrap_q       <= enable & inc_chain[N_DIGITS];
         m_prev_q     <= push_m;
         lap_prev_q   <= push_lap;
      end
   end

   // Prescaler advances only while counting and simply holds while paused or armed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
      end else if (!enable) begin
         presc_q <= '0;
      end else if (in_run) begin
         presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
      end
   end

   // Lap snapshot takes the count as it stood before this edge's increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lap_q <= '0;
      end else if (cnt_clr) begin
         lap_q <= '0;
      end else if (lap_capture) begin
         lap_q <= live_count;
      end
   end

   assign inc_chain[0] = tick;

   for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
      bcd_digit_cnt #(
         .MAX(digit_max(i, SEXAGESIMAL))
      ) u_digit (
         .clk  (clk),
         .reset(reset),
         .inc  (inc_chain[i]),
         .clr  (cnt_clr),
         .digit(live_count[4*i +: 4]),
         .carry(inc_chain[i+1])
      );
   end

   assign clk_count  = lap_active_q ? lap_q : live_count;
   assign running    = running_q;
   assign lap_active = lap_active_q;
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_lap_bcd.sv
// Bench for stopwatch_lap_bcd: two instances (TICK_DIV 1 and 4) share stimulus and are scored against an integer-count model.
module tb_stopwatch_lap_bcd;

   localparam int PERIOD  = 3600;
   localparam int M_IDLE  = 0;
   localparam int M_ARMED = 1;
   localparam int M_RUN   = 2;
   localparam int M_LAP   = 3;
   localparam int M_PAUSE = 4;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        enable   = 1'b0;
   logic        push_m   = 1'b0;
   logic        push_lap = 1'b0;
   logic [15:0] count0, count1;
   logic        run0, run1, lap0, lap1, wrap0, wrap1;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: count as a plain integer of elapsed ticks modulo 60*60.
   int st[2];
   int live[2];
   int lapv[2];
   int pre[2];
   bit wrapm[2];
   bit m_prev, l_prev;
   int tdiv[2] = '{1, 4};

   always #5 clk = ~clk;

   stopwatch_lap_bcd u_dut0 (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .push_m    (push_m),
      .push_lap  (push_lap),
      .clk_count (count0),
      .running   (run0),
      .lap_active(lap0),
      .wrap      (wrap0)
   );

   stopwatch_lap_bcd #(.TICK_DIV(4)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .push_m    (push_m),
      .push_lap  (push_lap),
      .clk_count (count1),
      .running   (run1),
      .lap_active(lap1),
      .wrap      (wrap1)
   );

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x;
      int radix;
      r = '0;
      x = v;
      for (int i = 0; i < 4; i++) begin
         radix = (i % 2 == 1) ? 6 : 10;
         r[4*i +: 4] = 4'(x % radix);
         x = x / radix;
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         st[k]    = M_IDLE;
         live[k]  = 0;
         lapv[k]  = 0;
         pre[k]   = 0;
         wrapm[k] = 1'b0;
      end
      m_prev = 1'b0;
      l_prev = 1'b0;
   endtask

   task automatic model_edge();
      bit mev, lev, run, tick, clr;
      int nst;
      mev = push_m && !m_prev;
      lev = push_lap && !l_prev && !mev;
      for (int k = 0; k < 2; k++) begin
         run  = (st[k] == M_RUN) || (st[k] == M_LAP);
         tick = run && (pre[k] == tdiv[k] - 1);
         if (!enable) begin
            st[k]    = M_IDLE;
            live[k]  = 0;
            lapv[k]  = 0;
            pre[k]   = 0;
            wrapm[k] = 1'b0;
         end else begin
            nst = st[k];
            clr = 1'b0;
            case (st[k])
               M_IDLE:  nst = M_ARMED;
               M_ARMED: if (mev) nst = M_RUN;
               M_RUN: begin
                  if (mev) nst = M_PAUSE;
                  else if (lev) begin
                     nst     = M_LAP;
                     lapv[k] = live[k];
                  end
               end
               M_LAP: begin
                  if (mev)      nst = M_PAUSE;
                  else if (lev) nst = M_RUN;
               end
               M_PAUSE: begin
                  if (mev) nst = M_RUN;
                  else if (lev) begin
                     nst = M_ARMED;
                     clr = 1'b1;
                  end
               end
               default: nst = M_IDLE;
            endcase
            wrapm[k] = tick && (live[k] == PERIOD - 1);
            if (tick) live[k] = (live[k] + 1) % PERIOD;
            if (run)  pre[k]  = tick ? 0 : pre[k] + 1;
            if (clr) begin
               live[k] = 0;
               lapv[k] = 0;
            end
            st[k] = nst;
         end
      end
      m_prev = push_m;
      l_prev = push_lap;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else       model_edge();
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("count0", 32'(count0), 32'(to_bcd(st[0] == M_LAP ? lapv[0] : live[0])));
      check("count1", 32'(count1), 32'(to_bcd(st[1] == M_LAP ? lapv[1] : live[1])));
      check("running0", 32'(run0), 32'(st[0] == M_RUN || st[0] == M_LAP));
      check("running1", 32'(run1), 32'(st[1] == M_RUN || st[1] == M_LAP));
      check("lap_active0", 32'(lap0), 32'(st[0] == M_LAP));
      check("lap_active1", 32'(lap1), 32'(st[1] == M_LAP));
      check("wrap0", 32'(wrap0), 32'(wrapm[0]));
      check("wrap1", 32'(wrap1), 32'(wrapm[1]));
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int n;
      #1 reset = 1'b1;
      #1 compare_all();
      check("reset_count0", 32'(count0), 32'h0);
      check("reset_running0", 32'(run0), 32'h0);
      cycle();
      reset  = 1'b0;
      enable = 1'b1;
      cycle();
      check("armed_idle_count", 32'(count0), 32'h0);

      // Start and count 60 ticks at TICK_DIV=1.
      push_m = 1'b1;
      cycle();
      push_m = 1'b0;
      check("started", 32'(run0), 32'h1);
      repeat (60) cycle();
      check("count_after_60", 32'(count0), 32'h0100);

      // Run up to the top and roll over.
      n = 0;
      while (live[0] != 3598 && n < 4000) begin
         cycle();
         n++;
      end
      check("reach_5958", 32'(count0), 32'h5958);
      cycle();
      check("count_5959", 32'(count0), 32'h5959);
      check("no_wrap_yet", 32'(wrap0), 32'h0);
      cycle();
      check("rollover", 32'(count0), 32'h0000);
      check("wrap_pulse", 32'(wrap0), 32'h1);
      cycle();
      check("wrap_drop", 32'(wrap0), 32'h0);
      check("after_wrap", 32'(count0), 32'h0001);

      // Lap freeze at 0123 and release 10 edges later.
      n = 0;
      while (live[0] != 83 && n < 200) begin
         cycle();
         n++;
      end
      check("at_0123", 32'(count0), 32'h0123);
      push_lap = 1'b1;
      cycle();
      push_lap = 1'b0;
      check("lap_frozen", 32'(count0), 32'h0123);
      check("lap_on", 32'(lap0), 32'h1);
      repeat (9) cycle();
      check("still_frozen", 32'(count0), 32'h0123);
      push_lap = 1'b1;
      cycle();
      push_lap = 1'b0;
      check("lap_release", 32'(count0), 32'h0134);
      check("lap_off", 32'(lap0), 32'h0);

      // Held start button toggles only once.
      push_m = 1'b1;
      repeat (20) cycle();
      push_m = 1'b0;
      check("held_m_paused", 32'(run0), 32'h0);
      check("held_m_count", 32'(count0), 32'h0135);
      cycle();
      push_m = 1'b1;
      cycle();
      push_m = 1'b0;
      check("resume", 32'(run0), 32'h1);
      repeat (3) cycle();
      push_m   = 1'b1;
      push_lap = 1'b1;
      cycle();
      push_m   = 1'b0;
      push_lap = 1'b0;
      check("both_pause", 32'(run0), 32'h0);
      check("both_no_lap", 32'(lap0), 32'h0);
      cycle();
      push_lap = 1'b1;
      cycle();
      push_lap = 1'b0;
      check("clear_count", 32'(count0), 32'h0);
      repeat (3) cycle();
      check("armed_waits", 32'(count0), 32'h0);

      // TICK_DIV=4: 12 run edges, pause, 4 more run edges.
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
      push_m = 1'b1;
      cycle();
      push_m = 1'b0;
      repeat (11) cycle();
      push_m = 1'b1;
      cycle();
      push_m = 1'b0;
      check("tdiv4_paused", 32'(count1), 32'h0003);
      repeat (4) cycle();
      push_m = 1'b1;
      cycle();
      push_m = 1'b0;
      repeat (4) cycle();
      check("tdiv4_count", 32'(count1), 32'h0004);

      // enable drop mid-run clears on the next edge.
      repeat (7) cycle();
      enable = 1'b0;
      cycle();
      check("en_off_count0", 32'(count0), 32'h0);
      check("en_off_count1", 32'(count1), 32'h0);
      check("en_off_run", 32'(run0), 32'h0);
      enable = 1'b1;
      cycle();
      push_m = 1'b1;
      cycle();
      push_m = 1'b0;
      repeat (25) cycle();

      // Reset mid-run clears at once.
      reset = 1'b1;
      #1;
      check("rst_count0", 32'(count0), 32'h0);
      check("rst_count1", 32'(count1), 32'h0);
      check("rst_run", 32'(run0), 32'h0);
      check("rst_wrap", 32'(wrap0), 32'h0);
      compare_all();
      cycle();
      reset = 1'b0;

      // Random button, enable and reset traffic.
      for (int c = 0; c < 1500; c++) begin
         reset  = ($urandom_range(0, 199) == 0);
         enable = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 5) == 0) push_m = ~push_m;
         if ($urandom_range(0, 3) == 0) push_lap = ~push_lap;
         cycle();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
